// File: rtl/am_envelope_decim.sv
// rtl/am_envelope_decim.sv - AM envelope detector: rectify, integrate-and-dump decimate, DC block
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   in_valid  in   x accepted on rising edges where this is 1
//   x         in   signed FIR output sample (IN_W)
//   out_valid out  one-cycle pulse when env/audio/dc update
//   env       out  unsigned mean magnitude over the last DECIM samples
//   audio     out  signed, saturated env minus DC estimate
//   dc        out  unsigned DC estimate after the update
module am_envelope_decim #(
    parameter int IN_W       = 16,
    parameter int DECIM      = 8,
    parameter int DECIM_LOG2 = 3,
    parameter int DC_SHIFT   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IN_W-1:0] x,
    output logic            out_valid,
    output logic [IN_W-1:0] env,
    output logic [IN_W-1:0] audio,
    output logic [IN_W-1:0] dc
);

    localparam int ACC_W = IN_W + DECIM_LOG2;
    localparam int DCA_W = IN_W + DC_SHIFT;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [IN_W-1:0]       env_s1_q, env_s1_d;
    logic                  s1_q, s1_d;
    logic [DCA_W-1:0]      dc_acc_q, dc_acc_d;
    logic                  out_valid_q, out_valid_d;
    logic [IN_W-1:0]       env_q, env_d;
    logic [IN_W-1:0]       audio_q, audio_d;
    logic [IN_W-1:0]       dc_q, dc_d;

    logic [IN_W-1:0]  mag;
    logic [ACC_W-1:0] acc_sum;
    logic [IN_W:0]    diff;
    logic [DCA_W-1:0] dc_acc_new;

    // Two's-complement negate in IN_W unsigned bits: the most negative
    // input maps to 2^(IN_W-1) exactly, which is representable unsigned.
    assign mag     = x[IN_W-1] ? (~x + {{(IN_W-1){1'b0}}, 1'b1}) : x;
    assign acc_sum = acc_q + {{DECIM_LOG2{1'b0}}, mag};

    // One bit wider than IN_W so env - dc (both 0..2^(IN_W-1)) never wraps.
    assign diff = {1'b0, env_s1_q} - {1'b0, dc_q};

    // dc_q always equals dc_acc_q >> DC_SHIFT, so it serves as dc_old.
    // The sum stays in range, so modulo DCA_W arithmetic is exact.
    assign dc_acc_new = dc_acc_q + DCA_W'(env_s1_q) - DCA_W'(dc_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        env_s1_d    = env_s1_q;
        s1_d        = 1'b0;
        dc_acc_d    = dc_acc_q;
        out_valid_d = 1'b0;
        env_d       = env_q;
        audio_d     = audio_q;
        dc_d        = dc_q;

        // Stage 1: accumulate, dump on the last sample of the frame.
        if (in_valid) begin
            if (cnt_q == DECIM_LOG2'(DECIM - 1)) begin
                env_s1_d = acc_sum[ACC_W-1:DECIM_LOG2];
                acc_d    = '0;
                cnt_d    = '0;
                s1_d     = 1'b1;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Stage 2: runs alongside the next frame's accumulation.
        if (s1_q) begin
            out_valid_d = 1'b1;
            env_d       = env_s1_q;
            case (state_q)
                ST_INIT: begin
                    // Seed the estimate with the first envelope so the
                    // blocker starts settled instead of ramping from zero.
                    dc_acc_d = {env_s1_q, {DC_SHIFT{1'b0}}};
                    dc_d     = env_s1_q;
                    audio_d  = '0;
                    state_d  = ST_RUN;
                end
                default: begin
                    if (!diff[IN_W] && diff[IN_W-1]) begin
                        audio_d = {1'b0, {(IN_W-1){1'b1}}};
                    end else if (diff[IN_W] && !diff[IN_W-1]) begin
                        audio_d = {1'b1, {(IN_W-1){1'b0}}};
                    end else begin
                        audio_d = diff[IN_W-1:0];
                    end
                    dc_acc_d = dc_acc_new;
                    dc_d     = dc_acc_new[DCA_W-1:DC_SHIFT];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            acc_q       <= '0;
            env_s1_q    <= '0;
            s1_q        <= 1'b0;
            dc_acc_q    <= '0;
            out_valid_q <= 1'b0;
            env_q       <= '0;
            audio_q     <= '0;
            dc_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            env_s1_q    <= env_s1_d;
            s1_q        <= s1_d;
            dc_acc_q    <= dc_acc_d;
            out_valid_q <= out_valid_d;
            env_q       <= env_d;
            audio_q     <= audio_d;
            dc_q        <= dc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign env       = env_q;
    assign audio     = audio_q;
    assign dc        = dc_q;

endmodule
